// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// plus the pending-write scoreboard used for read-after-write stall decisions.
`default_nettype none

module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rsv_valid,
    input  logic [4:0]           rsv_addr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*5-1:0]    req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wb_we,
    output logic [4:0]           wb_addr,
    output logic [XLEN-1:0]      wb_data,
    input  logic [4:0]           q_addr1,
    input  logic [4:0]           q_addr2,
    output logic                 q_busy1,
    output logic                 q_busy2,
    output logic [31:0]          busy_vec,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [31:0]     busy_q, busy_d;
    logic            wb_we_q, wb_we_d;
    logic [4:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            err_q, err_d;

    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic [PW:0]     cand_sum;
    logic [PW-1:0]   cand;
    logic [4:0]      sel_addr;
    logic [XLEN-1:0] sel_data;
    logic            dbl_issue;
    logic            unres_wr;

    // Search starts at ptr and wraps; only req_valid participates, never addr/data.
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NREQ)) begin
                cand_sum = cand_sum - (PW+1)'(NREQ);
            end
            cand = cand_sum[PW-1:0];
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            req_ready[k] = found && (gnt_idx == PW'(k));
        end
    end

    assign sel_addr = req_addr[int'(gnt_idx)*5 +: 5];
    assign sel_data = req_data[int'(gnt_idx)*XLEN +: XLEN];

    // A reservation colliding with the commit of the same register is legal.
    assign dbl_issue = rsv_valid && (rsv_addr != 5'd0) && busy_q[rsv_addr]
                       && !(wb_we_q && (wb_addr_q == rsv_addr));
    assign unres_wr  = found && (sel_addr != 5'd0) && !busy_q[sel_addr];

    always_comb begin
        ptr_d     = ptr_q;
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (found) begin
            wb_we_d   = (sel_addr != 5'd0);
            wb_addr_d = sel_addr;
            wb_data_d = sel_data;
            ptr_d     = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
        end

        busy_d = busy_q;
        if (wb_we_q) begin
            busy_d[wb_addr_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != 5'd0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q | dbl_issue | unres_wr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q     <= '0;
            busy_q    <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            err_q     <= err_d;
        end
    end

    assign wb_we    = wb_we_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign q_busy1  = busy_q[q_addr1];
    assign q_busy2  = busy_q[q_addr2];
    assign busy_vec = busy_q;
    assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a queue of expected register-file writes.
`default_nettype none

module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;

    logic                 clk;
    logic                 rst;
    logic                 rsv_valid;
    logic [4:0]           rsv_addr;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*5-1:0]    req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_we;
    logic [4:0]           wb_addr;
    logic [XLEN-1:0]      wb_data;
    logic [4:0]           q_addr1;
    logic [4:0]           q_addr2;
    logic                 q_busy1;
    logic                 q_busy2;
    logic [31:0]          busy_vec;
    logic                 err;

    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .q_busy1   (q_busy1),
        .q_busy2   (q_busy2),
        .busy_vec  (busy_vec),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every edge either retires one expected write or must show an idle write port.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_we",   64'(wb_we),   64'(e.we));
            chk("wb_addr", 64'(wb_addr), 64'(e.addr));
            chk("wb_data", 64'(wb_data), 64'(e.data));
        end else begin
            chk("wb_idle", 64'(wb_we), 64'd0);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [XLEN-1:0] d);
        req_valid[i]            = 1'b1;
        req_addr[i*5 +: 5]      = a;
        req_data[i*XLEN +: XLEN] = d;
    endtask

    task automatic expect_grant(input string tag, input logic [NREQ-1:0] rdy,
                                input logic we, input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_t e;
        #1;
        chk(tag, 64'(req_ready), 64'(rdy));
        e.we = we; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic reserve(input logic [4:0] a);
        rsv_valid = 1'b1;
        rsv_addr  = a;
        tick();
        rsv_valid = 1'b0;
        rsv_addr  = '0;
    endtask

    initial begin
        rst       = 1'b0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        q_addr1   = 5'd5;
        q_addr2   = 5'd7;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_we",   64'(wb_we),    64'd0);
        chk("rst_wb_addr", 64'(wb_addr),  64'd0);
        chk("rst_wb_data", 64'(wb_data),  64'd0);
        chk("rst_busy",    64'(busy_vec), 64'd0);
        chk("rst_err",     64'(err),      64'd0);
        rst = 1'b1;

        // Single write to x5 from requester 1
        reserve(5'd5);
        chk("rsv_q_busy1", 64'(q_busy1),  64'd1);
        chk("rsv_busy",    64'(busy_vec), 64'h20);
        tick();
        set_req(1, 5'd5, 32'hDEADBEEF);
        expect_grant("single_ready", 3'b010, 1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        req_valid = '0;
        chk("single_busy_pending", 64'(q_busy1), 64'd1);
        tick();
        chk("single_busy_cleared", 64'(q_busy1),  64'd0);
        chk("single_busy_vec",     64'(busy_vec), 64'd0);
        chk("single_err",          64'(err),      64'd0);

        // Round-robin from a fresh pointer; re-reservations coincide with commits
        rst = 1'b0;
        #2;
        rst = 1'b1;
        reserve(5'd1);
        reserve(5'd2);
        reserve(5'd3);
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 5'(i + 1), 32'hA000_0000 + 32'(i));
        end
        for (int k = 0; k < 6; k++) begin
            if (k >= 1 && k <= 3) begin
                rsv_valid = 1'b1;
                rsv_addr  = 5'(k);
            end else begin
                rsv_valid = 1'b0;
                rsv_addr  = '0;
            end
            expect_grant("rr_ready", 3'(1 << (k % 3)), 1'b1, 5'((k % 3) + 1),
                         32'hA000_0000 + 32'(k % 3));
            tick();
        end
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        req_valid = '0;
        tick();
        chk("rr_busy_vec", 64'(busy_vec), 64'd0);
        chk("rr_err",      64'(err),      64'd0);

        // x0 request together with an x0 reservation
        set_req(0, 5'd0, 32'h0000_1234);
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        expect_grant("x0_ready", 3'b001, 1'b0, 5'd0, 32'h0000_1234);
        tick();
        req_valid = '0;
        rsv_valid = 1'b0;
        chk("x0_busy_vec", 64'(busy_vec), 64'd0);
        chk("x0_err",      64'(err),      64'd0);

        // x7 re-reserved in the cycle its write-back commits
        reserve(5'd7);
        set_req(1, 5'd7, 32'h7777_7777);
        expect_grant("setclr_ready", 3'b010, 1'b1, 5'd7, 32'h7777_7777);
        tick();
        req_valid = '0;
        reserve(5'd7);
        chk("setclr_busy_vec", 64'(busy_vec), 64'h80);
        chk("setclr_q_busy2",  64'(q_busy2),  64'd1);
        chk("setclr_err",      64'(err),      64'd0);

        // Asynchronous reset while a write is pending on the port
        set_req(2, 5'd7, 32'hCAFE_F00D);
        expect_grant("pend_ready", 3'b100, 1'b1, 5'd7, 32'hCAFE_F00D);
        tick();
        req_valid = '0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_wb_we",   64'(wb_we),    64'd0);
        chk("arst_wb_addr", 64'(wb_addr),  64'd0);
        chk("arst_wb_data", 64'(wb_data),  64'd0);
        chk("arst_busy",    64'(busy_vec), 64'd0);
        chk("arst_err",     64'(err),      64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Double reservation of x9
        reserve(5'd9);
        chk("dbl_err_before", 64'(err), 64'd0);
        reserve(5'd9);
        chk("dbl_err_set", 64'(err), 64'd1);
        tick();
        chk("dbl_err_hold", 64'(err), 64'd1);

        // Unreserved write to x4 after reset still reaches the port
        rst = 1'b0;
        #2;
        rst = 1'b1;
        chk("unres_err_cleared", 64'(err), 64'd0);
        set_req(0, 5'd4, 32'h0000_0044);
        expect_grant("unres_ready", 3'b001, 1'b1, 5'd4, 32'h0000_0044);
        tick();
        req_valid = '0;
        chk("unres_err_set", 64'(err), 64'd1);
        tick();
        chk("unres_err_hold", 64'(err), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
